pc_unit: RTL and testbench

- Parametrised program-counter unit. Next generation of the single-cycle PC.
- Keeps the existing jump, branch and sequential update rules.
- Adds stall, an exception redirect, and a circular return-address stack (RAS) for call/return.
- Sits between control/ALU and instruction memory; `address` drives the fetch port each cycle.

---
 rtl/pc_unit.sv | 157 +++++++++++++++
 tb/tb_pc_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: jump/branch/sequential fetch address with stall, exception
// redirect and a circular return-address stack. Optional macro: PC_ALIGN_CHECK_EN.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h18C0,
  parameter logic [WIDTH-1:0] JUMP_BASE    = 32'h18C0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0080,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             exception,
  input  logic             jmpFlag,
  input  logic             callFlag,
  input  logic             retFlag,
  input  logic             branchFlag,
  input  logic             zeroFlag,
  input  logic [WIDTH-1:0] branchOffset,
  input  logic [WIDTH-1:0] jmpAddress,
  output logic [WIDTH-1:0] address,
  output logic             resetControl,
  output logic             rasEmpty,
  output logic             rasOverflow,
  output logic             rasUnderflow
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] addr_q, addr_d;
  logic             rc_q, rc_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             uf_q, uf_d;
  logic             mis_q, mis_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];

  logic [WIDTH-1:0] seq_addr, tgt;
  logic [PW-1:0]    wp_m1;
  logic             take, push;

  assign seq_addr = addr_q + WIDTH'(4);
  assign wp_m1    = wp_q - 1'b1;

  always_comb begin
    addr_d = addr_q;
    rc_d   = 1'b0;
    uf_d   = 1'b0;
    mis_d  = 1'b0;
    ovf_d  = ovf_q;
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    tgt    = '0;
    take   = 1'b0;
    push   = 1'b0;
    if (!stall) begin
      if (exception) begin
        addr_d = EXC_VECTOR;
        rc_d   = 1'b1;
      end else if (jmpFlag) begin
        tgt  = JUMP_BASE + jmpAddress;
        take = 1'b1;
        push = callFlag;
      end else if (retFlag && (cnt_q != '0)) begin
        tgt   = mem_q[wp_m1];
        take  = 1'b1;
        rc_d  = 1'b1;
        wp_d  = wp_m1;
        cnt_d = cnt_q - 1'b1;
      end else if (retFlag) begin
        addr_d = seq_addr;
        uf_d   = 1'b1;
      end else if (branchFlag && !zeroFlag) begin
        tgt  = addr_q + branchOffset - WIDTH'(4);
        take = 1'b1;
        rc_d = 1'b1;
      end else begin
        addr_d = seq_addr;
      end
      if (take) begin
`ifdef PC_ALIGN_CHECK_EN
        // A misaligned target traps instead of loading; a trapped call must not push.
        if (tgt[1:0] != 2'b00) begin
          addr_d = EXC_VECTOR;
          rc_d   = 1'b1;
          mis_d  = 1'b1;
          push   = 1'b0;
        end else begin
          addr_d = tgt;
        end
`else
        addr_d = tgt;
`endif
      end
      if (push) begin
        wp_d = wp_q + 1'b1;
        if (cnt_q == FULL_CNT) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= RESET_VECTOR;
      rc_q    <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      uf_q    <= 1'b0;
      mis_q   <= 1'b0;
      wp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      rc_q    <= rc_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      uf_q    <= uf_d;
      mis_q   <= mis_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pushed return address is the fall-through of the calling PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= seq_addr;
    end
  end

  assign address      = addr_q;
  assign resetControl = rc_q;
  assign rasEmpty     = empty_q;
  assign rasOverflow  = ovf_q;
  assign rasUnderflow = uf_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misaligned   = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven bench for pc_unit with an expected-value queue, plus async-reset sequence.
module tb_pc_unit;

  localparam int W  = 32;
  localparam int EW = W + 4;

  logic          clock, reset, stall, exception, jmpFlag, callFlag, retFlag;
  logic          branchFlag, zeroFlag;
  logic [W-1:0]  branchOffset, jmpAddress, address;
  logic          resetControl, rasEmpty, rasOverflow, rasUnderflow;
`ifdef PC_ALIGN_CHECK_EN
  logic          misaligned;
`endif

  pc_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .exception(exception),
    .jmpFlag(jmpFlag), .callFlag(callFlag), .retFlag(retFlag),
    .branchFlag(branchFlag), .zeroFlag(zeroFlag),
    .branchOffset(branchOffset), .jmpAddress(jmpAddress),
    .address(address), .resetControl(resetControl), .rasEmpty(rasEmpty),
    .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
`ifdef PC_ALIGN_CHECK_EN
    , .misaligned(misaligned)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [6:0]   f;    // stall exc jmp call ret br zero
    logic [W-1:0] off;
    logic [W-1:0] ja;
    logic [W-1:0] e_addr;
    logic [3:0]   e;    // rc empty ovf uf
  } vec_t;

  vec_t          vt[$];
  logic [EW-1:0] exp_q[$];
  int            tests_run = 0;
  int            tests_failed = 0;

  task automatic add(input logic [6:0] f, input logic [W-1:0] off, input logic [W-1:0] ja,
                     input logic [W-1:0] e_addr, input logic [3:0] e);
    vec_t v;
    v.f = f; v.off = off; v.ja = ja; v.e_addr = e_addr; v.e = e;
    vt.push_back(v);
  endtask

  task automatic check(input string name);
    logic [EW-1:0] got, exp;
    got = {address, resetControl, rasEmpty, rasOverflow, rasUnderflow};
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: no expected entry queued, got addr=%h rc/empty/ovf/uf=%b", name,
               got[EW-1:4], got[3:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s: got addr=%h rc/empty/ovf/uf=%b, expected addr=%h rc/empty/ovf/uf=%b",
                 name, got[EW-1:4], got[3:0], exp[EW-1:4], exp[3:0]);
      end
    end
  endtask

  task automatic drive(input vec_t v, input string name);
    {stall, exception, jmpFlag, callFlag, retFlag, branchFlag, zeroFlag} = v.f;
    branchOffset = v.off;
    jmpAddress   = v.ja;
    exp_q.push_back({v.e_addr, v.e});
    @(posedge clock);
    #1;
    check(name);
  endtask

  task automatic idle_inputs();
    {stall, exception, jmpFlag, callFlag, retFlag, branchFlag, zeroFlag} = '0;
    branchOffset = '0;
    jmpAddress   = '0;
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    idle_inputs();

    // sequential, jump, branch taken / not taken / negative
    add(7'b0000000, 0, 0,        32'h18C4, 4'b0100);
    add(7'b0000000, 0, 0,        32'h18C8, 4'b0100);
    add(7'b0010000, 0, 32'h40,   32'h1900, 4'b0100);
    add(7'b0000010, 32'h10, 0,   32'h190C, 4'b1100);
    add(7'b0000011, 32'h10, 0,   32'h1910, 4'b0100);
    add(7'b0000010, 32'hFFFF_FFF8, 0, 32'h1904, 4'b1100);
    // call / ret / underflow
    add(7'b0011000, 0, 32'h100,  32'h19C0, 4'b0000);
    add(7'b0000100, 0, 0,        32'h1908, 4'b1100);
    add(7'b0000100, 0, 0,        32'h190C, 4'b0101);
    add(7'b0000000, 0, 0,        32'h1910, 4'b0100);
    // exception beats jump; stalled ret pops on first free edge
    add(7'b0110000, 0, 32'h40,   32'h0080, 4'b1100);
    add(7'b0011000, 0, 0,        32'h18C0, 4'b0000);
    add(7'b1000100, 0, 0,        32'h18C0, 4'b0000);
    add(7'b1000100, 0, 0,        32'h18C0, 4'b0000);
    add(7'b0000100, 0, 0,        32'h0084, 4'b1100);
    // jmp+call+ret: call wins; lone callFlag ignored
    add(7'b0011100, 0, 32'h10,   32'h18D0, 4'b0000);
    add(7'b0000100, 0, 0,        32'h0088, 4'b1100);
    add(7'b0001000, 0, 32'h40,   32'h008C, 4'b0100);
    // five calls overflow a 4-deep stack
    add(7'b0011000, 0, 32'h0,    32'h18C0, 4'b0000);
    add(7'b0011000, 0, 32'h4,    32'h18C4, 4'b0000);
    add(7'b0011000, 0, 32'h8,    32'h18C8, 4'b0000);
    add(7'b0011000, 0, 32'hC,    32'h18CC, 4'b0000);
    add(7'b0011000, 0, 32'h10,   32'h18D0, 4'b0010);
    add(7'b0000100, 0, 0,        32'h18D0, 4'b1010);
    add(7'b0000100, 0, 0,        32'h18CC, 4'b1010);
    add(7'b0000100, 0, 0,        32'h18C8, 4'b1010);
    add(7'b0000100, 0, 0,        32'h18C4, 4'b1110);
    add(7'b0000100, 0, 0,        32'h18C8, 4'b0111);
    add(7'b1000000, 0, 0,        32'h18C8, 4'b0110);
    // exception, zero-offset branch, wrap-around
    add(7'b0100000, 0, 0,        32'h0080, 4'b1110);
    add(7'b0000010, 0, 0,        32'h007C, 4'b1110);
    add(7'b0010000, 0, 32'hFFFF_E740, 32'h0000_0000, 4'b0110);
    add(7'b0000010, 0, 0,        32'hFFFF_FFFC, 4'b1110);
    add(7'b0000000, 0, 0,        32'h0000_0000, 4'b0110);
    // two calls before the asynchronous reset
    add(7'b0011000, 0, 32'h0,    32'h18C0, 4'b0010);
    add(7'b0011000, 0, 32'h8,    32'h18C8, 4'b0010);

    repeat (3) begin
      @(posedge clock);
      #1;
      exp_q.push_back({32'h18C0, 4'b0100});
      check("reset_hold");
    end
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      drive(v, $sformatf("vec%0d", i));
    end

    // asynchronous reset between edges takes effect at once
    idle_inputs();
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back({32'h18C0, 4'b0100});
    check("async_reset_now");
    @(posedge clock);
    #1;
    exp_q.push_back({32'h18C0, 4'b0100});
    check("async_reset_hold");
    reset = 1'b1;
    add(7'b0000100, 0, 0, 32'h18C4, 4'b0101);
    v = vt[vt.size()-1];
    drive(v, "ret_after_reset");
    add(7'b0000000, 0, 0, 32'h18C8, 4'b0100);
    v = vt[vt.size()-1];
    drive(v, "seq_after_reset");

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
